// File: rtl/cmp_sort_pkg.sv
// ----------------------------------------------------------------------------
//  cmp_sort_pkg : shared types and comparator result encoding for cmp_sort_ctrl
//  Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cmp_sort_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } sort_state_e;

   // Comparator result is one-hot {gt, eq, lt}
   localparam logic [2:0] CMP_GT = 3'b100;
   localparam logic [2:0] CMP_EQ = 3'b010;
   localparam logic [2:0] CMP_LT = 3'b001;

endpackage

`default_nettype wire

// File: rtl/cmp_mag.sv
// ----------------------------------------------------------------------------
//  cmp_mag  : combinational unsigned W-bit magnitude comparator
//  Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cmp_mag
   import cmp_sort_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [2:0]   y
);

   always_comb begin
      if (a > b) begin
         y = CMP_GT;
      end else if (a == b) begin
         y = CMP_EQ;
      end else begin
         y = CMP_LT;
      end
   end

endmodule

`default_nettype wire

// File: rtl/cmp_sort_ctrl.sv
// ----------------------------------------------------------------------------
//  cmp_sort_ctrl : loads N words, bubble-sorts them with one shared comparator,
//                  then streams them out in ascending order
//  Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cmp_sort_ctrl
   import cmp_sort_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int W  = 4,
   localparam int SW = $clog2(N*(N-1)/2+1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic          busy,
   output logic          done,
   output logic [SW-1:0] swap_cnt
);

   localparam int IW = (N > 2) ? $clog2(N) : 1;

   sort_state_e   state_q, state_d;
   logic [IW-1:0] wr_q, wr_d;
   logic [IW-1:0] rd_q, rd_d;
   logic [IW-1:0] pass_q, pass_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [SW-1:0] swap_q, swap_d;
   logic [W-1:0]  mem_q [N];
   logic [W-1:0]  mem_d [N];

   logic [IW-1:0] idx_p1;
   logic [2:0]    cmp_y;

   assign idx_p1 = idx_q + IW'(1);

   cmp_mag #(.W(W)) u_cmp (
      .a (mem_q[idx_q]),
      .b (mem_q[idx_p1]),
      .y (cmp_y)
   );

   assign in_ready  = (state_q == LOAD);
   assign out_valid = (state_q == DRAIN);
   assign busy      = (state_q != LOAD);
   assign out_data  = mem_q[rd_q];
   assign swap_cnt  = swap_q;
   assign done      = (state_q == DRAIN) && out_ready && (rd_q == IW'(N-1));

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      pass_d  = pass_q;
      idx_d   = idx_q;
      swap_d  = swap_q;
      mem_d   = mem_q;
      case (state_q)
         LOAD: begin
            if (in_valid) begin
               mem_d[wr_q] = in_data;
               if (wr_q == IW'(N-1)) begin
                  wr_d    = '0;
                  swap_d  = '0;
                  state_d = SORT;
               end else begin
                  wr_d = wr_q + IW'(1);
               end
            end
         end
         SORT: begin
            // Strict greater-than keeps equal keys in their original order
            if (cmp_y == CMP_GT) begin
               mem_d[idx_q]  = mem_q[idx_p1];
               mem_d[idx_p1] = mem_q[idx_q];
               swap_d        = swap_q + SW'(1);
            end
            if (idx_q == IW'(N-2)) begin
               idx_d = '0;
               if (pass_q == IW'(N-2)) begin
                  pass_d  = '0;
                  state_d = DRAIN;
               end else begin
                  pass_d = pass_q + IW'(1);
               end
            end else begin
               idx_d = idx_p1;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (rd_q == IW'(N-1)) begin
                  rd_d    = '0;
                  state_d = LOAD;
               end else begin
                  rd_d = rd_q + IW'(1);
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
         wr_q    <= '0;
         rd_q    <= '0;
         pass_q  <= '0;
         idx_q   <= '0;
         swap_q  <= '0;
         for (int i = 0; i < N; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         pass_q  <= pass_d;
         idx_q   <= idx_d;
         swap_q  <= swap_d;
         for (int i = 0; i < N; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_cmp_sort_ctrl.sv
// ----------------------------------------------------------------------------
//  tb_cmp_sort_ctrl : scoreboard bench for cmp_sort_ctrl (N=4, W=4)
//  Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cmp_sort_ctrl;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int SW = 3;

   typedef struct {
      logic [W-1:0] d;
      logic         last;
      int           swaps;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          busy;
   logic          done;
   logic [SW-1:0] swap_cnt;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   cmp_sort_ctrl #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done),
      .swap_cnt  (swap_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every output handshake pops one expected word
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_word", int'(out_data), -1);
         end else begin
            e = sb.pop_front();
            check("out_data", int'(out_data), int'(e.d));
            check("done_pulse", int'(done), int'(e.last));
            check("swap_cnt", int'(swap_cnt), e.swaps);
         end
      end
   end

   task automatic load_words(input logic [W-1:0] vin [N], input bit jam);
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1;
         in_data  = vin[i];
         @(negedge clk);
         check("in_ready_load", int'(in_ready), 1);
         @(posedge clk); #1;
      end
      if (jam) begin
         in_valid = 1'b1;
         in_data  = 4'd7;
      end else begin
         in_valid = 1'b0;
      end
   endtask

   task automatic run_block(input logic [W-1:0] vin [N], input logic [W-1:0] vexp [N],
                            input int swaps, input bit stall, input bit jam);
      int   lat;
      int   n;
      int   bad;
      logic [W-1:0] held;
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.d = vexp[i]; e.last = (i == N-1); e.swaps = swaps;
         sb.push_back(e);
      end
      load_words(vin, jam);
      lat = 0;
      bad = 0;
      do begin
         @(negedge clk);
         lat++;
         if (in_ready || (!out_valid && !busy)) bad++;
      end while (!out_valid && lat < 40);
      check("latency", lat, 10);
      if (stall) begin
         @(posedge clk); #1;
         out_ready = 1'b0;
         held = out_data;
         for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_hold", int'(out_data), int'(held));
            if (in_ready || !out_valid) bad++;
            @(posedge clk); #1;
         end
         out_ready = 1'b1;
      end
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) bad++;
         if (done) break;
         n++;
         if (n > 40) break;
      end
      check("done_seen", int'(done), 1);
      in_valid = 1'b0;
      check("in_ready_low_while_busy", bad, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("post_in_ready", int'(in_ready), 1);
      check("post_out_valid", int'(out_valid), 0);
      check("post_busy", int'(busy), 0);
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_swap_cnt", int'(swap_cnt), 0);
      check("rst_out_data", int'(out_data), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_block('{4'd4, 4'd3, 4'd2, 4'd1}, '{4'd1, 4'd2, 4'd3, 4'd4}, 6, 1'b0, 1'b0);
      run_block('{4'd1, 4'd2, 4'd3, 4'd4}, '{4'd1, 4'd2, 4'd3, 4'd4}, 0, 1'b0, 1'b0);
      run_block('{4'd9, 4'd9, 4'd1, 4'd9}, '{4'd1, 4'd9, 4'd9, 4'd9}, 2, 1'b0, 1'b0);
      run_block('{4'd15, 4'd0, 4'd15, 4'd0}, '{4'd0, 4'd0, 4'd15, 4'd15}, 3, 1'b0, 1'b0);
      run_block('{4'd6, 4'd0, 4'd12, 4'd3}, '{4'd0, 4'd3, 4'd6, 4'd12}, 3, 1'b1, 1'b1);

      // Abort a sort partway through; the partial block must vanish
      load_words('{4'd4, 4'd3, 4'd2, 4'd1}, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", int'(in_ready), 1);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_swap_cnt", int'(swap_cnt), 0);
      @(posedge clk); #1;

      // 8,2,5,1 holds five inversions, so bubble sort swaps five times
      run_block('{4'd8, 4'd2, 4'd5, 4'd1}, '{4'd1, 4'd2, 4'd5, 4'd8}, 5, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
